// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the five-stage MIPS pipeline.
//
// Selects ALU operands through the forwarding muxes, computes the ALU result
// and owns the EX/MEM pipeline register. MUL runs on a DATA_W-cycle
// shift-and-add multiplier and holds the pipeline through ex_busy.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush                    squash the EX instruction, abort a multiply
//   idex_read_data1/2        register-file operands
//   idex_imm                 sign-extended immediate
//   idex_rd                  resolved destination register
//   idex_alu_src             1: ALU B is the immediate
//   idex_alu_op              ALU operation code
//   idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg
//                            control bits carried into EX/MEM
//   forwardA, forwardB       forwarding selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   memwb_write_data         write-back value in MEM/WB
//   ex_busy                  stall request while a multiply is in flight
//   exmem_*                  registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] idex_read_data1,
  input  logic [DATA_W-1:0] idex_read_data2,
  input  logic [DATA_W-1:0] idex_imm,
  input  logic [4:0]        idex_rd,
  input  logic              idex_alu_src,
  input  logic [2:0]        idex_alu_op,
  input  logic              idex_reg_write,
  input  logic              idex_mem_read,
  input  logic              idex_mem_write,
  input  logic              idex_mem_to_reg,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] memwb_write_data,
  output logic              ex_busy,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic [DATA_W-1:0] exmem_write_data,
  output logic [4:0]        exmem_rd,
  output logic              exmem_reg_write,
  output logic              exmem_mem_read,
  output logic              exmem_mem_write,
  output logic              exmem_mem_to_reg
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Destination and control of the MUL captured at entry, emitted in DONE.
  logic [4:0]        rd_hold_q, rd_hold_d;
  logic [3:0]        ctl_hold_q, ctl_hold_d;

  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              m2r_q, m2r_d;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b_fwd;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              mul_start;

  // Forwarding select: 10 = EX/MEM result, 01 = MEM/WB data, 00/11 = RF.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] exmem,
    input logic [DATA_W-1:0] memwb
  );
    case (sel)
      2'b10:   fwd_sel = exmem;
      2'b01:   fwd_sel = memwb;
      default: fwd_sel = rf;
    endcase
  endfunction

  assign op_a     = fwd_sel(forwardA, idex_read_data1, res_q, memwb_write_data);
  assign op_b_fwd = fwd_sel(forwardB, idex_read_data2, res_q, memwb_write_data);
  assign alu_b    = idex_alu_src ? idex_imm : op_b_fwd;

  // Single-cycle ALU. MUL is produced by the iterative multiplier, so the
  // combinational result for that code is unused and tied to zero.
  always_comb begin
    alu_res = '0;
    case (idex_alu_op)
      OP_AND: alu_res = op_a & alu_b;
      OP_OR:  alu_res = op_a | alu_b;
      OP_ADD: alu_res = op_a + alu_b;
      OP_SUB: alu_res = op_a - alu_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      OP_NOR: alu_res = ~(op_a | alu_b);
      OP_XOR: alu_res = op_a ^ alu_b;
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign mul_start = (state_q == S_IDLE) && (idex_alu_op == OP_MUL) &&
                     idex_reg_write && !flush;

  // Stall covers the entry cycle and every BUSY cycle; flush and reset
  // release it immediately.
  assign ex_busy = !rst && !flush && (mul_start || (state_q == S_BUSY));

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rd_hold_d  = rd_hold_q;
    ctl_hold_d = ctl_hold_q;
    // Default EX/MEM load is a bubble.
    res_d      = '0;
    wdata_d    = '0;
    rd_d       = '0;
    rw_d       = 1'b0;
    mr_d       = 1'b0;
    mw_d       = 1'b0;
    m2r_d      = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            mcand_d    = op_a;
            mplier_d   = alu_b;
            acc_d      = '0;
            cnt_d      = '0;
            rd_hold_d  = idex_rd;
            ctl_hold_d = {idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg};
            state_d    = S_BUSY;
          end else begin
            res_d   = alu_res;
            wdata_d = op_b_fwd;
            rd_d    = idex_rd;
            rw_d    = idex_reg_write;
            mr_d    = idex_mem_read;
            mw_d    = idex_mem_write;
            m2r_d   = idex_mem_to_reg;
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          res_d   = acc_q;
          wdata_d = op_b_fwd;
          rd_d    = rd_hold_q;
          {rw_d, mr_d, mw_d, m2r_d} = ctl_hold_q;
          // Always return to IDLE: the MUL still sitting on ID/EX this
          // cycle is the one just completed and must not restart.
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rd_hold_q  <= '0;
      ctl_hold_q <= '0;
      res_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      m2r_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rd_hold_q  <= rd_hold_d;
      ctl_hold_q <= ctl_hold_d;
      res_q      <= res_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      mr_q       <= mr_d;
      mw_q       <= mw_d;
      m2r_q      <= m2r_d;
    end
  end

  assign exmem_alu_result = res_q;
  assign exmem_write_data = wdata_q;
  assign exmem_rd         = rd_q;
  assign exmem_reg_write  = rw_q;
  assign exmem_mem_read   = mr_q;
  assign exmem_mem_write  = mw_q;
  assign exmem_mem_to_reg = m2r_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, sitting between the ID/EX register and the MEM stage. It applies the forwarding unit's select codes to pick operands from the register file, the EX/MEM result or the MEM/WB write-back data, runs the ALU, and owns the EX/MEM pipeline register. A 32-cycle iterative multiplier holds the pipeline through `ex_busy` while it runs.

## Interface
- `DATA_W`, 32, datapath width; the multiplier iteration count equals `DATA_W`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: squash the instruction in EX and abort any multiply in progress.
- `idex_read_data1`, `idex_read_data2` input DATA_W: register-file operands.
- `idex_imm` input DATA_W: sign-extended immediate.
- `idex_rd` input 5: destination register, already resolved (Rt or Rd).
- `idex_alu_src` input 1: 1 means ALU B is `idex_imm`.
- `idex_alu_op` input 3: operation code.
- `idex_reg_write`, `idex_mem_read`, `idex_mem_write`, `idex_mem_to_reg` input 1 each: control bits.
- `forwardA`, `forwardB` input 2: select codes from the forwarding unit.
- `memwb_write_data` input DATA_W: write-back value in MEM/WB.
- `ex_busy` output 1: stall request to the hazard unit, PC and IF/ID/ID/EX registers.
- `exmem_alu_result` output DATA_W: registered result.
- `exmem_write_data` output DATA_W: registered forwarded B operand, used as store data.
- `exmem_rd` output 5: registered destination register.
- `exmem_reg_write`, `exmem_mem_read`, `exmem_mem_write`, `exmem_mem_to_reg` output 1 each: registered control bits.

## Operation
- **Forward mux (A and B):**
  - 00 selects `idex_read_data`.
  - 10 selects the block's own `exmem_alu_result`.
  - 01 selects `memwb_write_data`.
  - 11 is treated as 00.
- **Operand routing:** `opB_fwd` is the B mux output. ALU B is `idex_alu_src ? idex_imm : opB_fwd`. `exmem_write_data` is always `opB_fwd`.
- **ALU op codes:**
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - 111 SLT, signed, giving 1 or 0 zero-extended.
  - 100 NOR, 101 XOR.
  - 011 MUL: low DATA_W bits of the product. Signed and unsigned give identical low bits.
  - ADD and SUB wrap modulo 2^DATA_W; no overflow flag.
- **Multiplier FSM states:** IDLE, BUSY, DONE.
  - IDLE: a MUL start condition is `idex_alu_op`=011, `idex_reg_write`=1 and `flush`=0.
    - On start, latch the forwarded A into `mcand` and the forwarded B (after `idex_alu_src` selection) into `mplier`.
    - Clear the accumulator and the counter, then go to BUSY.
    - `ex_busy`=1 combinationally in this cycle.
  - BUSY: each cycle, if `mplier[0]` then acc += `mcand`; `mcand` <<= 1; `mplier` >>= 1; count++.
    - After DATA_W iterations go to DONE.
    - `ex_busy`=1.
  - DONE: `ex_busy`=0. EX/MEM loads acc as the result plus the held ID/EX control, then the FSM returns to IDLE.
    - DONE never restarts a multiply, even though the same MUL is still present on the ID/EX inputs.
- **While `ex_busy`=1:** EX/MEM loads a bubble every cycle.
  - All four control bits are 0; `rd`=0; data is don't-care but driven as 0.
  - The bubble lets older instructions drain through MEM and WB.
- **Non-MUL ops in IDLE:** EX/MEM loads the ALU result and control every cycle.
- **`flush`=1:** EX/MEM loads a bubble and the FSM is forced to IDLE. `ex_busy` drops in the same cycle, and flush has priority over all else.
- **`rst`=1:** all EX/MEM outputs are 0, the FSM goes to IDLE, `ex_busy`=0, and the accumulator and counter are cleared.

## Timing
- Non-MUL latency is 1 cycle: ID/EX inputs in cycle N appear on `exmem_*` after the rising edge ending cycle N.
- **MUL timing:**
  - Entry is cycle E (IDLE).
  - BUSY covers cycles E+1..E+DATA_W.
  - DONE is cycle E+DATA_W+1.
  - The result is visible on `exmem_*` after the edge ending E+DATA_W+1.
  - `ex_busy` is high for cycles E..E+DATA_W, i.e. DATA_W+1 stall cycles (33 for DATA_W=32).
- Operands are sampled only at entry. Forwarding-source changes during BUSY have no effect.
- A MUL followed directly by a dependent instruction: that instruction sees forwardA/B=10 on the cycle after DONE, with the product in `exmem_alu_result`.
- Flush in any BUSY cycle: the bubble is loaded at that edge and the FSM is in IDLE the next cycle. No product is ever written.
- Reset asserted mid-multiply: the FSM is in IDLE on the next cycle and no partial result escapes.

## Test plan
- **Reset:** hold `rst` 2 cycles with random inputs -> all `exmem_*`=0 and `ex_busy`=0.
- **EX/MEM forwarding, op A:** ADD with rd=8, A=5, B=7, then a SUB whose A uses forwardA=10 with B=2 -> `exmem_alu_result`=12, then 10.
- **MEM/WB forwarding to store data:** a store with forwardB=01, `memwb_write_data`=0xDEADBEEF, `alu_src`=1, imm=4, A=0x100 -> result 0x104, `exmem_write_data`=0xDEADBEEF, `mem_write`=1.
- **SLT with immediate:** A=0xFFFFFFFF (-1), imm=1 -> result 1. Then A=5, imm=0xFFFFFFFE -> 0.
- **MUL:** 7 × 0xFFFFFFFD -> `ex_busy` high exactly 33 cycles, bubbles in EX/MEM meanwhile, then result 0xFFFFFFEB with `reg_write`=1, rd preserved.
- **Flush mid-multiply:** MUL 3×4 with `flush` pulsed in BUSY cycle 10 -> `ex_busy`=0 that cycle, EX/MEM bubble, the next ADD 1+1 produces 2 one cycle later, and a product of 12 never appears.
